// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and widths for the clock-gate controller.
//   state_e    : controller FSM state encoding
//   CntWidth   : width of the idle/wake cycle counter
//   StatWidth  : width of the saturating gated-cycle statistics counter
package clk_gate_ctrl_pkg;

  localparam int CntWidth  = 8;
  localparam int StatWidth = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IDLE_CNT = 2'd1,
    ST_GATED    = 2'd2,
    ST_WAKE     = 2'd3
  } state_e;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: decides when the core clock may be stopped, and
// sequences the wake back to a ready core. It does no gating itself. Its
// enable outputs drive an external prim_clock_gating cell.
//
// Ports
//   clk_i        free-running clock
//   rst_ni       synchronous active-low reset
//   idle_i       core reports idle (WFI)
//   wake_req_i   level wake request (IRQ / debug)
//   test_en_i    scan mode; forces en_o high
//   clr_i        synchronous clear of gated_cnt_o
//   en_o         clock enable to the gating cell
//   test_en_o    test enable to the gating cell
//   ready_o      core clock running and stable (RUN only)
//   wake_ack_o   one-cycle pulse when a wake sequence completes
//   gated_cnt_o  saturating count of cycles spent gated
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | clock running, core ready
// IDLE_CNT | core idle, counting IdleCycles before the clock is gated
// GATED    | clock enable low (unless test_en_i)
// WAKE     | clock re-enabled, counting WakeCycles before ready
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IdleCycles = 4,
  parameter int WakeCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 idle_i,
  input  logic                 wake_req_i,
  input  logic                 test_en_i,
  input  logic                 clr_i,
  output logic                 en_o,
  output logic                 test_en_o,
  output logic                 ready_o,
  output logic                 wake_ack_o,
  output logic [StatWidth-1:0] gated_cnt_o
);

  if (IdleCycles < 1 || IdleCycles > 255) begin : g_bad_idle
    $error("clk_gate_ctrl: IdleCycles=%0d outside 1..255", IdleCycles);
  end
  if (WakeCycles < 1 || WakeCycles > 255) begin : g_bad_wake
    $error("clk_gate_ctrl: WakeCycles=%0d outside 1..255", WakeCycles);
  end

  localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);
  localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeCycles - 1);

  state_e              state, state_nxt;
  logic [CntWidth-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_RUN;
      cnt         <= '0;
      wake_ack_o  <= 1'b0;
      gated_cnt_o <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      // Only a completed wake acknowledges; an aborted idle count does not.
      wake_ack_o <= (state == ST_WAKE) && (state_nxt == ST_RUN);
      if (clr_i) begin
        gated_cnt_o <= '0;
      end else if (state == ST_GATED && gated_cnt_o != '1) begin
        gated_cnt_o <= gated_cnt_o + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RUN: begin
        if (idle_i && !wake_req_i) begin
          state_nxt = ST_IDLE_CNT;
          cnt_nxt   = '0;
        end
      end
      ST_IDLE_CNT: begin
        if (!idle_i || wake_req_i) begin
          state_nxt = ST_RUN;
        end else if (cnt == IdleLast) begin
          state_nxt = ST_GATED;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GATED: begin
        if (wake_req_i || !idle_i) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = '0;
        end
      end
      ST_WAKE: begin
        // Inputs are deliberately ignored so the wake always runs to completion.
        if (cnt == WakeLast) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Enable comes from registered state; test_en_i is the only direct path.
  assign en_o      = (state != ST_GATED) || test_en_i;
  assign test_en_o = test_en_i;
  assign ready_o   = (state == ST_RUN);

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        idle_i;
  logic        wake_req_i;
  logic        test_en_i;
  logic        clr_i;
  logic        en_o;
  logic        test_en_o;
  logic        ready_o;
  logic        wake_ack_o;
  logic [15:0] gated_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  clk_gate_ctrl #(.IdleCycles(4), .WakeCycles(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .idle_i      (idle_i),
    .wake_req_i  (wake_req_i),
    .test_en_i   (test_en_i),
    .clr_i       (clr_i),
    .en_o        (en_o),
    .test_en_o   (test_en_o),
    .ready_o     (ready_o),
    .wake_ack_o  (wake_ack_o),
    .gated_cnt_o (gated_cnt_o)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic en, input logic rdy,
                          input logic ack, input logic [15:0] gc);
    chk({tag, ".en"},    en_o,        en);
    chk({tag, ".ready"}, ready_o,     rdy);
    chk({tag, ".ack"},   wake_ack_o,  ack);
    chk({tag, ".gcnt"},  gated_cnt_o, gc);
  endtask

  initial begin
    rst_ni = 1'b0; idle_i = 1'b0; wake_req_i = 1'b0; test_en_i = 1'b0; clr_i = 1'b0;
    step(2);
    chk_outs("reset", 1, 1, 0, 16'h0);
    chk("reset.test_en_o", test_en_o, 1'b0);

    // Idle entry: IDLE_CNT after one edge, GATED IdleCycles edges later.
    rst_ni = 1'b1; idle_i = 1'b1;
    step(1);
    chk_outs("idle_enter", 1, 0, 0, 16'h0);
    step(3);
    chk_outs("idle_last", 1, 0, 0, 16'h0);
    step(1);
    chk_outs("gated_first", 0, 0, 0, 16'h0);
    step(5);
    chk_outs("gated_5", 0, 0, 0, 16'h5);

    // Scan mode forces the enable without disturbing the FSM.
    test_en_i = 1'b1;
    #1;
    chk("test.en", en_o, 1'b1);
    chk("test.test_en_o", test_en_o, 1'b1);
    step(2);
    chk_outs("test_gated", 1, 0, 0, 16'h7);
    test_en_i = 1'b0;
    #1;
    chk("test_off.en", en_o, 1'b0);
    chk("test_off.test_en_o", test_en_o, 1'b0);

    // Wake: enable returns on the first edge, ready + ack WakeCycles later.
    wake_req_i = 1'b1;
    step(1);
    chk_outs("wake_1", 1, 0, 0, 16'h8);
    wake_req_i = 1'b0;
    step(1);
    chk_outs("wake_2", 1, 0, 0, 16'h8);
    step(1);
    chk_outs("wake_done", 1, 1, 1, 16'h8);

    // Simultaneous idle and wake: wake wins, stays in RUN; ack was one cycle.
    wake_req_i = 1'b1;
    step(1);
    chk_outs("both_1", 1, 1, 0, 16'h8);
    step(6);
    chk_outs("both_7", 1, 1, 0, 16'h8);

    // Short idle burst aborts back to RUN with no ack.
    wake_req_i = 1'b0;
    step(3);
    chk_outs("short_idle", 1, 0, 0, 16'h8);
    idle_i = 1'b0;
    step(1);
    chk_outs("abort_run", 1, 1, 0, 16'h8);
    step(1);
    chk_outs("abort_run2", 1, 1, 0, 16'h8);

    // Wake request during IDLE_CNT also aborts.
    idle_i = 1'b1;
    step(2);
    chk_outs("idle_again", 1, 0, 0, 16'h8);
    wake_req_i = 1'b1;
    step(1);
    chk_outs("idle_wake_abort", 1, 1, 0, 16'h8);
    wake_req_i = 1'b0; idle_i = 1'b0;

    clr_i = 1'b1;
    step(1);
    chk_outs("clr_run", 1, 1, 0, 16'h0);
    clr_i = 1'b0;

    // Saturation of the gated-cycle counter.
    idle_i = 1'b1;
    step(5);
    chk_outs("sat_gated", 0, 0, 0, 16'h0);
    step(65534);
    chk_outs("sat_fffe", 0, 0, 0, 16'hFFFE);
    step(1);
    chk_outs("sat_ffff", 0, 0, 0, 16'hFFFF);
    step(2);
    chk_outs("sat_hold", 0, 0, 0, 16'hFFFF);
    clr_i = 1'b1;
    step(1);
    chk_outs("sat_clr", 0, 0, 0, 16'h0);
    clr_i = 1'b0;
    step(1);
    chk_outs("sat_after_clr", 0, 0, 0, 16'h1);

    // Reset in the middle of a wake sequence.
    wake_req_i = 1'b1;
    step(1);
    chk_outs("rst_wake", 1, 0, 0, 16'h2);
    rst_ni = 1'b0;
    step(1);
    chk_outs("rst_in_wake", 1, 1, 0, 16'h0);
    rst_ni = 1'b1; wake_req_i = 1'b0; idle_i = 1'b0;
    step(1);
    chk_outs("post_rst_1", 1, 1, 0, 16'h0);
    step(1);
    chk_outs("post_rst_2", 1, 1, 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter IdleCycles, default 4: consecutive idle cycles required before gating; legal range 1..255.
REQ-002 Parameter WakeCycles, default 2: cycles of ungated clock before the core is declared ready; legal range 1..255.
REQ-003 clk_i  input  1  free-running clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 idle_i  input  1  core reports sleep/idle (WFI) state.
REQ-006 wake_req_i  input  1  wake request (pending IRQ or debug request), level-sensitive.
REQ-007 test_en_i  input  1  scan/test mode; forces the clock enable high.
REQ-008 clr_i  input  1  synchronous clear of the gated-cycle counter.
REQ-009 en_o  output  1  clock enable; drives en_i of prim_clock_gating.
REQ-010 test_en_o  output  1  copy of test_en_i; drives test_en_i of prim_clock_gating.
REQ-011 ready_o  output  1  high only in RUN.
REQ-012 wake_ack_o  output  1  single-cycle pulse on completion of a wake sequence.
REQ-013 gated_cnt_o  output  16  saturating count of cycles spent in GATED.

Function
REQ-014 FSM states: RUN, IDLE_CNT, GATED, WAKE; 8-bit internal cycle counter cnt.
REQ-015 RUN: idle_i=1 and wake_req_i=0 -> IDLE_CNT with cnt=0; otherwise stay in RUN.
REQ-016 IDLE_CNT: idle_i=0 or wake_req_i=1 -> RUN; else if cnt==IdleCycles-1 -> GATED; else cnt+1.
REQ-017 GATED: wake_req_i=1 or idle_i=0 -> WAKE with cnt=0; else stay.
REQ-018 WAKE: cnt==WakeCycles-1 -> RUN; else cnt+1; idle_i and wake_req_i are ignored in WAKE.
REQ-019 en_o = (state != GATED) OR test_en_i, decoded from registered state only, with no input-to-output combinational path except test_en_i.
REQ-020 Latency to gate: with idle_i high from cycle t and wake_req_i low, IDLE_CNT is entered at edge t+1, GATED at edge t+1+IdleCycles, and en_o is low from that cycle.
REQ-021 Latency to wake: a wake condition sampled in GATED at edge w makes en_o high from cycle w, RUN is entered at edge w+WakeCycles, and wake_ack_o is high for exactly that first RUN cycle.
REQ-022 wake_ack_o is registered; it asserts only on a WAKE->RUN transition, never on an IDLE_CNT->RUN abort.
REQ-023 Simultaneous idle_i=1 and wake_req_i=1: wake has priority, and the FSM never leaves RUN or IDLE_CNT toward GATED.
REQ-024 test_en_i does not alter FSM transitions or counters; only en_o is forced.
REQ-025 gated_cnt_o increments by 1 for each cycle in GATED, saturates at 0xFFFF, and clr_i=1 loads 0, taking priority over increment.
REQ-026 Parameter violations are flagged by elaboration-time assertions.

Reset
REQ-027 On rst_ni=0 at a clock edge: state=RUN, cnt=0, wake_ack_o=0, gated_cnt_o=0.
REQ-028 Consequently, during and after reset en_o=1 and ready_o=1.
REQ-029 Reset asserted in any state, including GATED or WAKE mid-sequence, returns to RUN on the next edge with no wake_ack_o pulse.

Structure
REQ-030 Package clk_gate_ctrl_pkg holds the FSM state enum, the counter width constant (8), and the statistics width constant (16).
REQ-031 There are no sub-modules: the FSM, cycle counter and saturating statistics counter are inline in clk_gate_ctrl.
REQ-032 The block contains no latches and no derived clocks, and performs no gating itself.

Verification
REQ-033 Defaults; idle_i=1 from cycle 10, wake_req_i=0 -> en_o=0 from cycle 15; gated_cnt_o increments each cycle after that.
REQ-034 Gated; wake_req_i=1 at cycle 30 -> en_o=1 at cycle 30, wake_ack_o=1 and ready_o=1 exactly at cycle 32.
REQ-035 idle_i high for 3 cycles then low -> en_o never drops, FSM returns to RUN, no wake_ack_o.
REQ-036 Gated with test_en_i=1 -> en_o=1 while state stays GATED; test_en_o follows test_en_i.
REQ-037 gated_cnt_o preloaded to 0xFFFE by 3 gated cycles -> value 0xFFFF held; clr_i=1 -> 0 next cycle.
REQ-038 rst_ni=0 during WAKE -> RUN, en_o=1, wake_ack_o stays 0, gated_cnt_o=0.
